// File: rtl/gap_cell_pkg.sv
// Shared types, predecessor indices and scoring helpers for the pair-gap DP cell.
package gap_cell_pkg;

  typedef enum logic [1:0] {
    GM_XY   = 2'd0,
    GM_YZ   = 2'd1,
    GM_XZ   = 2'd2,
    GM_OPEN = 2'd3
  } gap_mode_e;

  localparam int unsigned PRED_M   = 0;
  localparam int unsigned PRED_IXY = 1;
  localparam int unsigned PRED_IYZ = 2;
  localparam int unsigned PRED_IXZ = 3;
  localparam int unsigned PRED_IX  = 4;
  localparam int unsigned PRED_IY  = 5;
  localparam int unsigned PRED_IZ  = 6;
  localparam int unsigned NUM_PRED = 7;
  localparam int unsigned IDX_W    = 3;

  // Clamp a width-extended score into the signed range of a w-bit score.
  function automatic longint sat_score(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // 1 selects the extend penalty, 0 the open penalty.
  function automatic logic pen_sel(input gap_mode_e mode, input int unsigned idx);
    logic ext;
    ext = 1'b0;
    case (mode)
      GM_XY:   ext = (idx == PRED_IXY) || (idx == PRED_IX) || (idx == PRED_IY);
      GM_YZ:   ext = (idx == PRED_IYZ) || (idx == PRED_IY) || (idx == PRED_IZ);
      GM_XZ:   ext = (idx == PRED_IXZ) || (idx == PRED_IX) || (idx == PRED_IZ);
      default: ext = 1'b0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/gap_cell_pipe_max2_idx.sv
// Combinational compare-select of two scores; index tracking exists only when
// GAP_CELL_TRACEBACK_EN is defined, with the lower index winning a tie.
module max2_idx
  import gap_cell_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W-1:0]     a_score,
`ifdef GAP_CELL_TRACEBACK_EN
  input  logic        [IDX_W-1:0] a_idx,
`endif
  input  logic signed [W-1:0]     b_score,
`ifdef GAP_CELL_TRACEBACK_EN
  input  logic        [IDX_W-1:0] b_idx,
  output logic        [IDX_W-1:0] y_idx,
`endif
  output logic signed [W-1:0]     y_score
);

  logic pick_b;

  always_comb begin
    pick_b = (b_score > a_score);
`ifdef GAP_CELL_TRACEBACK_EN
    if ((b_score == a_score) && (b_idx < a_idx)) pick_b = 1'b1;
    y_idx = pick_b ? b_idx : a_idx;
`endif
    y_score = pick_b ? b_score : a_score;
  end

endmodule

// File: rtl/gap_cell_pipe.sv
// Three-stage pipelined pair-gap DP cell (Ixy / Iyz / Ixz) with valid/ready on both
// sides. Define GAP_CELL_TRACEBACK_EN to add the winning-index output idx_out.
module gap_cell_pipe
  import gap_cell_pkg::*;
#(
  parameter int          SCORE_W = 12,
  parameter int          PAIR_W  = 2,
  parameter int unsigned G0      = 2,
  parameter int unsigned GE      = 1,
  parameter int          CNT_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        mode,
  input  logic signed [PAIR_W-1:0]          pair_score,
  input  logic [NUM_PRED-1:0][SCORE_W-1:0]  pred,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [SCORE_W-1:0]         score_out,
  output logic [CNT_W-1:0]                  cell_cnt
`ifdef GAP_CELL_TRACEBACK_EN
  ,
  output logic [IDX_W-1:0]                  idx_out
`endif
);

  localparam int EXT_W = SCORE_W + 2;
  localparam logic [EXT_W-1:0] G0_X = EXT_W'(G0);
  localparam logic [EXT_W-1:0] GE_X = EXT_W'(GE);

  gap_mode_e        mode_e;
  logic [EXT_W-1:0] pair_x;

  assign mode_e = gap_mode_e'(mode);
  assign pair_x = {{(EXT_W - PAIR_W){pair_score[PAIR_W-1]}}, pair_score};

  // ---------------- element arithmetic (feeds S1) ----------------
  logic signed [SCORE_W-1:0] e_next [NUM_PRED];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRED; gi++) begin : g_elem
      logic [EXT_W-1:0]        pred_x;
      logic [EXT_W-1:0]        pen_x;
      logic signed [EXT_W-1:0] e_wide;

      assign pred_x = {{2{pred[gi][SCORE_W-1]}}, pred[gi]};
      assign pen_x  = pen_sel(mode_e, gi) ? GE_X : G0_X;
      // Two guard bits keep pred - pen + pair exact before clamping.
      assign e_wide = $signed(pred_x - pen_x + pair_x);
      assign e_next[gi] = SCORE_W'(sat_score(longint'(e_wide), SCORE_W));
    end
  endgenerate

  // ---------------- stage control ----------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic out_valid_reg;
  logic load1;
  logic load2;
  logic load3;

  assign load3    = !out_valid_reg || out_ready;
  assign load2    = !s2_valid_reg || load3;
  assign load1    = !s1_valid_reg || load2;
  assign in_ready = load1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (load1) s1_valid_reg  <= in_valid;
      if (load2) s2_valid_reg  <= s1_valid_reg;
      if (load3) out_valid_reg <= s2_valid_reg;
    end
  end

  // ---------------- S1: saturated elements ----------------
  logic signed [SCORE_W-1:0] s1_e_reg [NUM_PRED];

  always_ff @(posedge clk) begin
    if (load1 && in_valid) s1_e_reg <= e_next;
  end

  // ---------------- S2: pairwise max ----------------
  logic signed [SCORE_W-1:0] s2_score_next [4];
  logic signed [SCORE_W-1:0] s2_score_reg  [4];
`ifdef GAP_CELL_TRACEBACK_EN
  logic [IDX_W-1:0] s2_idx_next [4];
  logic [IDX_W-1:0] s2_idx_reg  [4];
`endif

  max2_idx #(.W(SCORE_W)) u_s2_a (
    .a_score (s1_e_reg[PRED_M]),
`ifdef GAP_CELL_TRACEBACK_EN
    .a_idx   (IDX_W'(PRED_M)),
    .b_idx   (IDX_W'(PRED_IXY)),
    .y_idx   (s2_idx_next[0]),
`endif
    .b_score (s1_e_reg[PRED_IXY]),
    .y_score (s2_score_next[0])
  );

  max2_idx #(.W(SCORE_W)) u_s2_b (
    .a_score (s1_e_reg[PRED_IYZ]),
`ifdef GAP_CELL_TRACEBACK_EN
    .a_idx   (IDX_W'(PRED_IYZ)),
    .b_idx   (IDX_W'(PRED_IXZ)),
    .y_idx   (s2_idx_next[1]),
`endif
    .b_score (s1_e_reg[PRED_IXZ]),
    .y_score (s2_score_next[1])
  );

  max2_idx #(.W(SCORE_W)) u_s2_c (
    .a_score (s1_e_reg[PRED_IX]),
`ifdef GAP_CELL_TRACEBACK_EN
    .a_idx   (IDX_W'(PRED_IX)),
    .b_idx   (IDX_W'(PRED_IY)),
    .y_idx   (s2_idx_next[2]),
`endif
    .b_score (s1_e_reg[PRED_IY]),
    .y_score (s2_score_next[2])
  );

  assign s2_score_next[3] = s1_e_reg[PRED_IZ];
`ifdef GAP_CELL_TRACEBACK_EN
  assign s2_idx_next[3] = IDX_W'(PRED_IZ);
`endif

  always_ff @(posedge clk) begin
    if (load2 && s1_valid_reg) begin
      s2_score_reg <= s2_score_next;
`ifdef GAP_CELL_TRACEBACK_EN
      s2_idx_reg   <= s2_idx_next;
`endif
    end
  end

  // ---------------- S3: final max tree ----------------
  logic signed [SCORE_W-1:0] lo_score;
  logic signed [SCORE_W-1:0] hi_score;
  logic signed [SCORE_W-1:0] s3_score_next;
  logic signed [SCORE_W-1:0] score_reg;
`ifdef GAP_CELL_TRACEBACK_EN
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] s3_idx_next;
  logic [IDX_W-1:0] idx_reg;
`endif

  max2_idx #(.W(SCORE_W)) u_s3_lo (
    .a_score (s2_score_reg[0]),
`ifdef GAP_CELL_TRACEBACK_EN
    .a_idx   (s2_idx_reg[0]),
    .b_idx   (s2_idx_reg[1]),
    .y_idx   (lo_idx),
`endif
    .b_score (s2_score_reg[1]),
    .y_score (lo_score)
  );

  max2_idx #(.W(SCORE_W)) u_s3_hi (
    .a_score (s2_score_reg[2]),
`ifdef GAP_CELL_TRACEBACK_EN
    .a_idx   (s2_idx_reg[2]),
    .b_idx   (s2_idx_reg[3]),
    .y_idx   (hi_idx),
`endif
    .b_score (s2_score_reg[3]),
    .y_score (hi_score)
  );

  max2_idx #(.W(SCORE_W)) u_s3_top (
    .a_score (lo_score),
`ifdef GAP_CELL_TRACEBACK_EN
    .a_idx   (lo_idx),
    .b_idx   (hi_idx),
    .y_idx   (s3_idx_next),
`endif
    .b_score (hi_score),
    .y_score (s3_score_next)
  );

  // Output registers only move on a real load, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_reg <= '0;
`ifdef GAP_CELL_TRACEBACK_EN
      idx_reg   <= '0;
`endif
    end else if (load3 && s2_valid_reg) begin
      score_reg <= s3_score_next;
`ifdef GAP_CELL_TRACEBACK_EN
      idx_reg   <= s3_idx_next;
`endif
    end
  end

  // ---------------- accepted-result counter ----------------
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else if (out_valid_reg && out_ready) cnt_reg <= cnt_reg + 1'b1;
  end

  assign out_valid = out_valid_reg;
  assign score_out = score_reg;
  assign cell_cnt  = cnt_reg;
`ifdef GAP_CELL_TRACEBACK_EN
  assign idx_out   = idx_reg;
`endif

endmodule
